// File: rtl/conv2d_pkg.sv
// Shared constants and types for the conv2d frame sequencer and its counters.
package conv2d_pkg;

  localparam int FILTER_SIZE = 3;
  localparam int PIXEL_DATAW = 8;
  localparam int IMG_W       = 512;
  localparam int COEF_W      = FILTER_SIZE * FILTER_SIZE * PIXEL_DATAW;

  // Frame phases, in the order a frame walks through them.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KRST  = 3'd1,
    TOP   = 3'd2,
    ROWS  = 3'd3,
    BOT   = 3'd4,
    FLUSH = 3'd5,
    DONE  = 3'd6
  } seq_state_t;

  // Full 3x3 coefficient set as presented to the kernel.
  typedef logic [COEF_W-1:0] coef_vec_t;

endpackage

// File: rtl/conv2d_beat_counter.sv
// Generic up-counter with synchronous clear and a terminal-value compare.
// Clear has priority over increment so a wrap and a restart never collide.
module conv2d_beat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             at_term
);
  import conv2d_pkg::*;

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next count: clear wins, otherwise step on enable, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign at_term = (count_q == term);

endmodule

// File: rtl/conv2d_frame_sequencer.sv
// Frame-level controller in front of the streaming 3x3 convolution kernel.
// Wraps each raw frame in a one-pixel zero border, holds the coefficients
// for the whole frame, pulses the kernel reset at frame start and pushes
// zero flush beats until every output pixel has been seen leaving the kernel.
module conv2d_frame_sequencer #(
  parameter int IMG_W       = conv2d_pkg::IMG_W,
  parameter int ROW_W       = 10,
  parameter int PIXEL_DATAW = conv2d_pkg::PIXEL_DATAW,
  parameter int KRST_CYCLES = 2,
  parameter int FLUSH_MAX   = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [ROW_W-1:0]                     cfg_height,
  input  logic [conv2d_pkg::FILTER_SIZE*conv2d_pkg::FILTER_SIZE*PIXEL_DATAW-1:0] cfg_f,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic                                 err_flush,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [PIXEL_DATAW-1:0]               s_x,
  output logic                                 k_reset,
  output logic [conv2d_pkg::FILTER_SIZE*conv2d_pkg::FILTER_SIZE*PIXEL_DATAW-1:0] k_f,
  output logic                                 k_valid,
  input  logic                                 k_ready,
  output logic [PIXEL_DATAW-1:0]               k_x,
  input  logic                                 mon_valid,
  input  logic                                 mon_ready
);
  import conv2d_pkg::*;

  localparam int KF_W  = FILTER_SIZE * FILTER_SIZE * PIXEL_DATAW;
  localparam int COL_W = $clog2(IMG_W + 2);
  localparam int FL_W  = $clog2(FLUSH_MAX + 1);
  localparam int OUT_W = $clog2(IMG_W * (2 ** ROW_W)) + 1;
  localparam int KC_W  = (KRST_CYCLES > 1) ? $clog2(KRST_CYCLES) : 1;

  // Registered frame state.
  seq_state_t       state_d, state_q;
  logic [KC_W-1:0]  krst_d, krst_q;
  logic [ROW_W-1:0] row_d, row_q;
  logic [ROW_W-1:0] h_d, h_q;
  logic [KF_W-1:0]  kf_d, kf_q;
  logic             err_d, err_q;
  logic             frame_done_d, frame_done_q;

  // Combinational helpers.
  logic             accept_s;
  logic             busy_s;
  logic             xfer_s;
  logic             col_pad_s;
  logic [COL_W-1:0] col_cnt_s;
  logic             col_last_s;
  logic [FL_W-1:0]  flush_cnt_s;
  logic             flush_last_s;
  logic [OUT_W-1:0] out_cnt_s;
  logic [OUT_W-1:0] wh_s;
  logic             out_full_s;
  logic             out_en_s;

  assign busy_s    = (state_q != IDLE);
  assign xfer_s    = k_valid && k_ready;
  assign col_pad_s = (col_cnt_s == '0) || col_last_s;
  assign wh_s      = OUT_W'(IMG_W) * OUT_W'(h_q);
  assign out_en_s  = busy_s && mon_valid && mon_ready && !out_full_s;

  // Column position inside the padded row; wraps on the right-pad transfer.
  conv2d_beat_counter #(.WIDTH(COL_W)) u_col_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept_s || (xfer_s && col_last_s)),
    .en      (xfer_s),
    .term    (COL_W'(IMG_W + 1)),
    .count   (col_cnt_s),
    .at_term (col_last_s)
  );

  // Flush beats already sent in this frame.
  conv2d_beat_counter #(.WIDTH(FL_W)) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept_s),
    .en      (xfer_s && (state_q == FLUSH)),
    .term    (FL_W'(FLUSH_MAX)),
    .count   (flush_cnt_s),
    .at_term (flush_last_s)
  );

  // Output pixels seen leaving the kernel; saturates at W*H.
  conv2d_beat_counter #(.WIDTH(OUT_W)) u_out_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept_s),
    .en      (out_en_s),
    .term    (wh_s),
    .count   (out_cnt_s),
    .at_term (out_full_s)
  );

  // Kernel-side beat generation: zero pads, pass-through pixels, flush zeros.
  always_comb begin
    k_valid = 1'b0;
    k_x     = '0;
    s_ready = 1'b0;
    case (state_q)
      TOP, BOT: begin
        k_valid = 1'b1;
      end
      ROWS: begin
        if (col_pad_s) begin
          k_valid = 1'b1;
        end else begin
          k_valid = s_valid;
          k_x     = s_x;
          s_ready = k_ready;
        end
      end
      FLUSH: begin
        k_valid = !out_full_s && (flush_cnt_s < FL_W'(FLUSH_MAX));
      end
      default: begin
        k_valid = 1'b0;
      end
    endcase
  end

  // Frame FSM next-state, configuration latch and error flag.
  always_comb begin
    state_d      = state_q;
    krst_d       = krst_q;
    row_d        = row_q;
    h_d          = h_q;
    kf_d         = kf_q;
    err_d        = err_q;
    accept_s     = 1'b0;
    frame_done_d = out_en_s && (out_cnt_s == (wh_s - OUT_W'(1)));
    case (state_q)
      IDLE: begin
        if (start && (cfg_height != '0)) begin
          accept_s = 1'b1;
          h_d      = cfg_height;
          kf_d     = cfg_f;
          err_d    = 1'b0;
          krst_d   = '0;
          row_d    = '0;
          state_d  = KRST;
        end else begin
          state_d  = IDLE;
        end
      end
      KRST: begin
        if (krst_q == KC_W'(KRST_CYCLES - 1)) begin
          krst_d  = '0;
          state_d = TOP;
        end else begin
          krst_d  = krst_q + KC_W'(1);
        end
      end
      TOP: begin
        if (xfer_s && col_last_s) begin
          state_d = ROWS;
        end else begin
          state_d = TOP;
        end
      end
      ROWS: begin
        if (xfer_s && col_last_s) begin
          if (row_q == (h_q - ROW_W'(1))) begin
            row_d   = '0;
            state_d = BOT;
          end else begin
            row_d   = row_q + ROW_W'(1);
          end
        end else begin
          state_d = ROWS;
        end
      end
      BOT: begin
        if (xfer_s && col_last_s) begin
          state_d = FLUSH;
        end else begin
          state_d = BOT;
        end
      end
      FLUSH: begin
        if (out_full_s) begin
          state_d = DONE;
        end else if (flush_last_s) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = FLUSH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and configuration registers; reset drops straight back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      krst_q       <= '0;
      row_q        <= '0;
      h_q          <= '0;
      kf_q         <= '0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      krst_q       <= krst_d;
      row_q        <= row_d;
      h_q          <= h_d;
      kf_q         <= kf_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = busy_s;
  assign frame_done = frame_done_q;
  assign err_flush  = err_q;
  assign k_f        = kf_q;
  assign k_reset    = reset || (state_q == KRST);

endmodule

// File: tb/tb_conv2d_frame_sequencer.sv
// Self-checking bench for conv2d_frame_sequencer: table of frame scenarios
// run against a grid/queue reference model, plus reset and ignored-start
// sequences.
module tb_conv2d_frame_sequencer;

  localparam int W    = 512;
  localparam int RW   = 10;
  localparam int PD   = 8;
  localparam int KRST = 2;
  localparam int FMAX = 8;
  localparam int KLAT = 3;
  localparam int FW   = 9 * PD;

  typedef struct {
    int             h;
    int             sv_pct;
    int             kr_pct;
    bit             mon_stuck;
    bit             row_stall;
    int             abort_at;
    logic [FW-1:0]  f;
    bit             exp_err;
    int             exp_done;
  } frame_vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [RW-1:0]   cfg_height;
  logic [FW-1:0]   cfg_f;
  logic            busy;
  logic            frame_done;
  logic            err_flush;
  logic            s_valid;
  logic            s_ready;
  logic [PD-1:0]   s_x;
  logic            k_reset;
  logic [FW-1:0]   k_f;
  logic            k_valid;
  logic            k_ready;
  logic [PD-1:0]   k_x;
  logic            mon_valid;
  logic            mon_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv2d_frame_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_height (cfg_height),
    .cfg_f      (cfg_f),
    .busy       (busy),
    .frame_done (frame_done),
    .err_flush  (err_flush),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_x        (s_x),
    .k_reset    (k_reset),
    .k_f        (k_f),
    .k_valid    (k_valid),
    .k_ready    (k_ready),
    .k_x        (k_x),
    .mon_valid  (mon_valid),
    .mon_ready  (mon_ready)
  );

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] rand_f();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[FW-1:0];
  endfunction

  function automatic frame_vec_t mk(input int h, input int sv, input int kr, input bit stuck,
                                    input bit rstall, input int abort_at, input bit e, input int d);
    frame_vec_t v;
    v.h = h; v.sv_pct = sv; v.kr_pct = kr; v.mon_stuck = stuck; v.row_stall = rstall;
    v.abort_at = abort_at; v.f = rand_f(); v.exp_err = e; v.exp_done = d;
    return v;
  endfunction

  // Run one frame against the reference model: padded grid, source queue,
  // kernel with KLAT beats of latency, saturating output count.
  task automatic run_frame(input frame_vec_t v);
    int n_grid, wh, idx, flush_sent, out_cnt, pending, fin, stall, cyc, done_pulses, rr, cc, n;
    bit stalled, done_next, err_exp, interior, exp_kv, exp_sr, aborted;
    logic [PD-1:0] img[$];
    logic [PD-1:0] src[$];
    logic [PD-1:0] exp_x;
    n_grid = (W + 2) * (v.h + 2);
    wh = W * v.h;
    for (int i = 0; i < wh; i++) img.push_back(PD'($urandom_range(255)));
    src = img;
    idx = 0; flush_sent = 0; out_cnt = 0; pending = 0; fin = 0; stall = 0;
    done_pulses = 0; stalled = 1'b0; done_next = 1'b0; err_exp = 1'b0; aborted = 1'b0;

    @(posedge clk); #1;
    start = 1'b1; cfg_height = RW'(v.h); cfg_f = v.f;
    s_valid = 1'b0; k_ready = 1'b0; mon_valid = 1'b0; mon_ready = 1'b1;
    @(negedge clk);
    check("idle_busy_before_start", busy, 1'b0);
    @(posedge clk); #1;

    for (cyc = 1; cyc <= 40000 && fin < 3 && !aborted; cyc++) begin
      if (v.abort_at != 0 && idx >= v.abort_at) begin
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        check("abort_k_reset_during", k_reset, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_k_reset", k_reset, 1'b1);
        check("abort_k_f", k_f, '0);
        check("abort_k_valid", k_valid, 1'b0);
        check("abort_s_ready", s_ready, 1'b0);
        check("abort_err", err_flush, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0; s_valid = 1'b0; k_ready = 1'b0; mon_valid = 1'b0;
        aborted = 1'b1;
      end else begin
        // drive this cycle's inputs
        start = (idx < n_grid) && ($urandom_range(99) < 5);
        cfg_height = RW'($urandom_range(1023));
        cfg_f = rand_f();
        if (v.row_stall && !stalled && idx == 2 * (W + 2) + W + 1) begin
          stall = 20; stalled = 1'b1;
        end
        if (stall > 0) begin
          s_valid = 1'b0; stall--;
        end else begin
          s_valid = (src.size() > 0) && ($urandom_range(99) < v.sv_pct);
        end
        if (s_valid) s_x = src[0];
        else s_x = PD'($urandom_range(255));
        k_ready = ($urandom_range(99) < v.kr_pct);
        mon_valid = !v.mon_stuck && (pending > 0);
        mon_ready = 1'b1;

        @(negedge clk);
        interior = 1'b0; exp_x = '0;
        if (idx < n_grid) begin
          rr = idx / (W + 2); cc = idx % (W + 2);
          interior = (rr >= 1) && (rr <= v.h) && (cc >= 1) && (cc <= W);
          if (interior) exp_x = img[(rr - 1) * W + (cc - 1)];
          exp_kv = (cyc > KRST) && (interior ? s_valid : 1'b1);
        end else begin
          exp_kv = (fin == 0) && (out_cnt < wh) && (flush_sent < FMAX);
        end
        exp_sr = (cyc > KRST) && interior && k_ready;

        check("k_reset", k_reset, (cyc <= KRST));
        check("busy", busy, (fin < 2));
        check("k_valid", k_valid, exp_kv);
        check("s_ready", s_ready, exp_sr);
        if (exp_kv) check("k_x", k_x, exp_x);
        check("k_f_stable", k_f, v.f);
        check("err_flush", err_flush, err_exp);
        check("frame_done", frame_done, done_next);
        if (frame_done) done_pulses++;

        if (idx >= n_grid) begin
          if (fin == 0 && !((out_cnt < wh) && (flush_sent < FMAX))) begin
            if (out_cnt < wh) err_exp = 1'b1;
            fin = 1;
          end else if (fin > 0) begin
            fin++;
          end
        end

        if (exp_kv && k_ready) begin
          n = idx + flush_sent - KLAT;
          if (n >= 0 && n < n_grid && (n / (W + 2)) >= 2 && (n % (W + 2)) >= 2) pending++;
          if (idx < n_grid) begin
            if (interior) void'(src.pop_front());
            idx++;
          end else begin
            flush_sent++;
          end
        end
        done_next = 1'b0;
        if (mon_valid && mon_ready) begin
          pending--;
          if (out_cnt < wh) begin
            done_next = (out_cnt == wh - 1);
            out_cnt++;
          end
        end
        @(posedge clk); #1;
      end
    end

    s_valid = 1'b0; k_ready = 1'b0; mon_valid = 1'b0; start = 1'b0;
    if (!aborted) begin
      check("frame_completed_in_budget", (fin >= 3), 1'b1);
      check("grid_beats", idx, n_grid);
      check("source_drained", src.size(), 0);
      check("frame_done_pulses", done_pulses, v.exp_done);
      check("err_flush_end", err_flush, v.exp_err);
      if (v.exp_err) check("flush_beats_overrun", flush_sent, FMAX);
      else check("flush_beats_ok", (flush_sent >= KLAT && flush_sent <= FMAX), 1'b1);
    end
  endtask

  frame_vec_t vecs[6];

  initial begin
    reset = 1'b1; start = 1'b0; cfg_height = '0; cfg_f = '1;
    s_valid = 1'b1; s_x = 8'hA5; k_ready = 1'b1; mon_valid = 1'b1; mon_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_err", err_flush, 1'b0);
    check("rst_k_reset", k_reset, 1'b1);
    check("rst_k_valid", k_valid, 1'b0);
    check("rst_k_x", k_x, '0);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_k_f", k_f, '0);
    @(posedge clk); #1;
    reset = 1'b0; s_valid = 1'b0; mon_valid = 1'b0;
    @(negedge clk);
    check("post_rst_k_reset", k_reset, 1'b0);

    // start with zero height must be ignored
    @(posedge clk); #1;
    start = 1'b1; cfg_height = '0; cfg_f = rand_f();
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("h0_busy", busy, 1'b0);
    check("h0_k_reset", k_reset, 1'b0);
    check("h0_k_valid", k_valid, 1'b0);
    check("h0_k_f", k_f, '0);
    check("h0_frame_done", frame_done, 1'b0);

    vecs[0] = mk(3, 70, 75, 1'b0, 1'b0, 0, 1'b0, 1);
    vecs[1] = mk(2, 90, 90, 1'b0, 1'b1, 0, 1'b0, 1);
    vecs[2] = mk(2, 80, 80, 1'b1, 1'b0, 0, 1'b1, 0);
    vecs[3] = mk(1, 60, 70, 1'b0, 1'b0, 0, 1'b0, 1);
    vecs[4] = mk(3, 85, 85, 1'b0, 1'b0, 3 * (W + 2) + 7, 1'b0, 0);
    vecs[5] = mk(1, 100, 100, 1'b0, 1'b0, 0, 1'b0, 1);
    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
